mem_bus_arbiter: RTL and testbench

Two-master arbiter and transaction sequencer for the single data-memory bus (address, write data, read data, write/read enables, byte enables). Master 0 is the multicycle CPU datapath. Master 1 is a secondary bus master such as a DMA or debug port. The block grants one master at a time, drives the shared bus with that master's latched command, inserts programmable wait states, waits for slave ready, returns read data and pulses an acknowledge. It sits between the datapath's data-bus outputs and the memory/peripheral bus.

---
 rtl/mem_bus_arbiter_if.sv | 58 +++++
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_if
//  Description : Bundles both masters' request ports and the shared data-memory
//                bus. The arbiter connects through the slave modport; a bus
//                master model or bench connects through the master modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if;
    // master 0 (CPU datapath)
    logic        iReq0;
    logic        iWe0;
    logic [31:0] iAddr0;
    logic [31:0] iWData0;
    logic [3:0]  iBE0;
    logic        oAck0;
    logic [31:0] oRData0;
    // master 1 (DMA / debug)
    logic        iReq1;
    logic        iWe1;
    logic [31:0] iAddr1;
    logic [31:0] iWData1;
    logic [3:0]  iBE1;
    logic        oAck1;
    logic [31:0] oRData1;
    // shared memory bus
    logic [31:0] oAddress;
    logic [31:0] oWriteData;
    logic        oWriteEnable;
    logic        oReadEnable;
    logic [3:0]  oByteEnable;
    logic [31:0] iReadData;
    logic        iReady;
    // status
    logic [1:0]  oGrant;
    logic        oBusy;

    modport slave (
        input  iReq0, iWe0, iAddr0, iWData0, iBE0,
        output oAck0, oRData0,
        input  iReq1, iWe1, iAddr1, iWData1, iBE1,
        output oAck1, oRData1,
        output oAddress, oWriteData, oWriteEnable, oReadEnable, oByteEnable,
        input  iReadData, iReady,
        output oGrant, oBusy
    );

    modport master (
        output iReq0, iWe0, iAddr0, iWData0, iBE0,
        input  oAck0, oRData0,
        output iReq1, iWe1, iAddr1, iWData1, iBE1,
        input  oAck1, oRData1,
        input  oAddress, oWriteData, oWriteEnable, oReadEnable, oByteEnable,
        output iReadData, iReady,
        input  oGrant, oBusy
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Two-master arbiter and transaction sequencer for the data
//                memory bus. Grants one master, drives its latched command,
//                inserts WAIT_CYCLES wait states, waits for iReady, returns
//                read data and pulses a one-cycle acknowledge.
//                Optional feature macro: ARB_ROUND_ROBIN_EN
//                  defined   - round-robin on ties (master 0 wins first tie)
//                  undefined - fixed priority, master 0 wins ties
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic               iCLK,
    input  logic               iRST,
    mem_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

    state_t      r_state;
    logic        r_owner;       // 0 = master 0, 1 = master 1
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_wen;
    logic        r_ren;
    logic        r_ack0;
    logic        r_ack1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic [1:0]  r_grant;
`ifdef ARB_ROUND_ROBIN_EN
    logic        r_last;        // master granted most recently
`endif

    logic        w_any;
    logic        w_pick;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;

    // Winner selection and its command fields, only consumed in IDLE
    always_comb begin
        w_any = bus.iReq0 | bus.iReq1;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.iReq0 && bus.iReq1)
            w_pick = ~r_last;
        else
            w_pick = ~bus.iReq0;
`else
        w_pick = ~bus.iReq0;
`endif
        w_we    = w_pick ? bus.iWe1    : bus.iWe0;
        w_addr  = w_pick ? bus.iAddr1  : bus.iAddr0;
        w_wdata = w_pick ? bus.iWData1 : bus.iWData0;
        w_be    = w_pick ? bus.iBE1    : bus.iBE0;
    end

    // Transaction sequencer: IDLE -> ACCESS -> RESP -> IDLE
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_cnt    <= 4'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_be     <= 4'd0;
            r_wen    <= 1'b0;
            r_ren    <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
            r_grant  <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
            r_last   <= 1'b1;
`endif
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_be    <= w_be;
                        r_wen   <= w_we;
                        r_ren   <= ~w_we;
                        r_cnt   <= c_wait_init;
                        r_grant <= w_pick ? 2'b10 : 2'b01;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last  <= w_pick;
`endif
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // wait states first, then iReady is honoured
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (bus.iReady) begin
                        if (r_ren) begin
                            if (r_owner)
                                r_rdata1 <= bus.iReadData;
                            else
                                r_rdata0 <= bus.iReadData;
                        end
                        r_ack0  <= ~r_owner;
                        r_ack1  <= r_owner;
                        r_wen   <= 1'b0;
                        r_ren   <= 1'b0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_grant <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.oAddress     = r_addr;
    assign bus.oWriteData   = r_wdata;
    assign bus.oByteEnable  = r_be;
    assign bus.oWriteEnable = r_wen;
    assign bus.oReadEnable  = r_ren;
    assign bus.oAck0        = r_ack0;
    assign bus.oAck1        = r_ack1;
    assign bus.oRData0      = r_rdata0;
    assign bus.oRData1      = r_rdata1;
    assign bus.oGrant       = r_grant;
    assign bus.oBusy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench for mem_bus_arbiter. Three instances with
//                WAIT_CYCLES = 0, 2 and 3 share clock and reset. Expected
//                acknowledges are queued when stimulus is driven and popped
//                by a monitor when an instance acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          inst;
        logic        m;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];

    mem_bus_arbiter_if bi0 ();
    mem_bus_arbiter_if bi2 ();
    mem_bus_arbiter_if bi3 ();

    mem_bus_arbiter #(.WAIT_CYCLES(0)) u_dut0 (.iCLK(clk), .iRST(rst_n), .bus(bi0));
    mem_bus_arbiter #(.WAIT_CYCLES(2)) u_dut2 (.iCLK(clk), .iRST(rst_n), .bus(bi2));
    mem_bus_arbiter #(.WAIT_CYCLES(3)) u_dut3 (.iCLK(clk), .iRST(rst_n), .bus(bi3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        m_ack0 [3];
    logic        m_ack1 [3];
    logic [31:0] m_rd0  [3];
    logic [31:0] m_rd1  [3];
    logic        m_stb  [3];
    assign m_ack0[0] = bi0.oAck0;  assign m_ack1[0] = bi0.oAck1;
    assign m_ack0[1] = bi2.oAck0;  assign m_ack1[1] = bi2.oAck1;
    assign m_ack0[2] = bi3.oAck0;  assign m_ack1[2] = bi3.oAck1;
    assign m_rd0[0]  = bi0.oRData0; assign m_rd1[0] = bi0.oRData1;
    assign m_rd0[1]  = bi2.oRData0; assign m_rd1[1] = bi2.oRData1;
    assign m_rd0[2]  = bi3.oRData0; assign m_rd1[2] = bi3.oRData1;
    assign m_stb[0]  = bi0.oWriteEnable | bi0.oReadEnable;
    assign m_stb[1]  = bi2.oWriteEnable | bi2.oReadEnable;
    assign m_stb[2]  = bi3.oWriteEnable | bi3.oReadEnable;

    // Scoreboard monitor: every acknowledge must match the oldest expectation
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (m_ack0[k] || m_ack1[k]) begin
                exp_t e;
                checks++;
                if (m_ack0[k] && m_ack1[k]) begin
                    errors++;
                    $display("FAIL sb_ack_onehot inst=%0d ack0=1 ack1=1 required only one", k);
                end else if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_ack inst=%0d ack1=%0b required no ack", k, m_ack1[k]);
                end else begin
                    e = q.pop_front();
                    if (e.inst != k || e.m !== m_ack1[k]) begin
                        errors++;
                        $display("FAIL sb_owner got inst=%0d master=%0b required inst=%0d master=%0b",
                                 k, m_ack1[k], e.inst, e.m);
                    end
                    if (e.rd) begin
                        checks++;
                        if ((e.m ? m_rd1[k] : m_rd0[k]) !== e.data) begin
                            errors++;
                            $display("FAIL sb_rdata inst=%0d got=%h required=%h",
                                     k, (e.m ? m_rd1[k] : m_rd0[k]), e.data);
                        end
                    end
                    checks++;
                    if (m_stb[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL sb_strobe_in_resp inst=%0d got=%0b required=0", k, m_stb[k]);
                    end
                end
            end
        end
    end

    task automatic drive_idle();
        bi0.iReq0 = 0; bi0.iWe0 = 0; bi0.iAddr0 = 0; bi0.iWData0 = 0; bi0.iBE0 = 0;
        bi0.iReq1 = 0; bi0.iWe1 = 0; bi0.iAddr1 = 0; bi0.iWData1 = 0; bi0.iBE1 = 0;
        bi2.iReq0 = 0; bi2.iWe0 = 0; bi2.iAddr0 = 0; bi2.iWData0 = 0; bi2.iBE0 = 0;
        bi2.iReq1 = 0; bi2.iWe1 = 0; bi2.iAddr1 = 0; bi2.iWData1 = 0; bi2.iBE1 = 0;
        bi3.iReq0 = 0; bi3.iWe0 = 0; bi3.iAddr0 = 0; bi3.iWData0 = 0; bi3.iBE0 = 0;
        bi3.iReq1 = 0; bi3.iWe1 = 0; bi3.iAddr1 = 0; bi3.iWData1 = 0; bi3.iBE1 = 0;
        bi0.iReadData = 0; bi0.iReady = 1;
        bi2.iReadData = 0; bi2.iReady = 1;
        bi3.iReadData = 0; bi3.iReady = 1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int  n;
        bit  seen;
        apply_reset();
        @(negedge clk);
        checks++;
        if ({bi3.oGrant, bi3.oBusy, bi3.oAck0, bi3.oAck1} !== 5'b0) begin
            errors++;
            $display("FAIL reset_status got grant=%b busy=%b ack0=%b ack1=%b required all 0",
                     bi3.oGrant, bi3.oBusy, bi3.oAck0, bi3.oAck1);
        end
        checks++;
        if ({bi3.oAddress, bi3.oWriteData, bi3.oByteEnable, bi3.oWriteEnable, bi3.oReadEnable} !== 70'b0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h wdata=%h be=%b we=%b re=%b required all 0",
                     bi3.oAddress, bi3.oWriteData, bi3.oByteEnable, bi3.oWriteEnable, bi3.oReadEnable);
        end
        checks++;
        if ({bi3.oRData0, bi3.oRData1} !== 64'b0) begin
            errors++;
            $display("FAIL reset_rdata got r0=%h r1=%h required 0", bi3.oRData0, bi3.oRData1);
        end
        // master 1 write, then abort with reset one cycle into ACCESS
        @(posedge clk); #1;
        bi3.iReq1 = 1; bi3.iWe1 = 1; bi3.iAddr1 = 32'h0000_0040;
        bi3.iWData1 = 32'hDEAD_BEEF; bi3.iBE1 = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bi3.oBusy && n < 10);
        checks++;
        if (bi3.oBusy !== 1'b1) begin
            errors++;
            $display("FAIL reset_grant_timeout busy=%b required 1", bi3.oBusy);
        end
        rst_n = 1'b0;
        bi3.iReq1 = 0;
        #1;
        checks++;
        if ({bi3.oGrant, bi3.oBusy, bi3.oAck1, bi3.oWriteEnable, bi3.oAddress} !== 37'b0) begin
            errors++;
            $display("FAIL reset_abort got grant=%b busy=%b ack1=%b we=%b addr=%h required all 0",
                     bi3.oGrant, bi3.oBusy, bi3.oAck1, bi3.oWriteEnable, bi3.oAddress);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bi3.oAck1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_ack got ack1 seen=1 required 0");
        end
        // next request served normally
        q.push_back('{inst: 2, m: 1'b0, rd: 1'b0, data: 32'h0});
        @(posedge clk); #1;
        bi3.iReq0 = 1; bi3.iWe0 = 1; bi3.iAddr0 = 32'h0000_0080;
        bi3.iWData0 = 32'h0BAD_F00D; bi3.iBE0 = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bi3.oAck0 && n < 20);
        checks++;
        if (bi3.oAck0 !== 1'b1 || n != 6) begin
            errors++;
            $display("FAIL reset_recover got ack0=%b after %0d negedges required ack0=1 after 6", bi3.oAck0, n);
        end
        bi3.iReq0 = 0;
    endtask

    task automatic test_single_read();
        q.push_back('{inst: 0, m: 1'b0, rd: 1'b1, data: 32'hCAFE_F00D});
        @(posedge clk); #1;
        bi0.iReadData = 32'hCAFE_F00D;
        bi0.iReq0 = 1; bi0.iWe0 = 0; bi0.iAddr0 = 32'h1000_0004; bi0.iBE0 = 4'hF;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bi0.oReadEnable !== 1'b1 || bi0.oWriteEnable !== 1'b0 || bi0.oAddress !== 32'h1000_0004) begin
            errors++;
            $display("FAIL read_bus got re=%b we=%b addr=%h required re=1 we=0 addr=10000004",
                     bi0.oReadEnable, bi0.oWriteEnable, bi0.oAddress);
        end
        checks++;
        if (bi0.oGrant !== 2'b01 || bi0.oBusy !== 1'b1) begin
            errors++;
            $display("FAIL read_grant got grant=%b busy=%b required 01 1", bi0.oGrant, bi0.oBusy);
        end
        @(negedge clk);
        checks++;
        if (bi0.oAck0 !== 1'b1 || bi0.oRData0 !== 32'hCAFE_F00D || bi0.oReadEnable !== 1'b0) begin
            errors++;
            $display("FAIL read_ack got ack0=%b rdata0=%h re=%b required 1 cafef00d 0",
                     bi0.oAck0, bi0.oRData0, bi0.oReadEnable);
        end
        bi0.iReq0 = 0;
        bi0.iReadData = 32'h1111_2222;
        @(negedge clk);
        checks++;
        if (bi0.oAck0 !== 1'b0 || bi0.oGrant !== 2'b00 || bi0.oBusy !== 1'b0 || bi0.oRData0 !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL read_idle got ack0=%b grant=%b busy=%b rdata0=%h required 0 00 0 cafef00d",
                     bi0.oAck0, bi0.oGrant, bi0.oBusy, bi0.oRData0);
        end
    endtask

    task automatic test_wait_states();
        int  cnt;
        bit  acked;
        bit  bad;
        q.push_back('{inst: 1, m: 1'b1, rd: 1'b0, data: 32'h0});
        @(posedge clk); #1;
        bi2.iReq1 = 1; bi2.iWe1 = 1; bi2.iAddr1 = 32'h2000_0010;
        bi2.iWData1 = 32'h1234_5678; bi2.iBE1 = 4'b0011;
        cnt = 0; acked = 0; bad = 0;
        for (int i = 0; i < 20 && !acked; i++) begin
            @(negedge clk);
            if (bi2.oAck0) bad = 1;
            if (bi2.oWriteEnable) begin
                cnt++;
                if (bi2.oByteEnable !== 4'b0011 || bi2.oWriteData !== 32'h1234_5678) bad = 1;
            end
            if (bi2.oAck1) acked = 1;
        end
        bi2.iReq1 = 0;
        checks++;
        if (!acked || cnt != 3) begin
            errors++;
            $display("FAIL wait_len got ack1_seen=%0b we_cycles=%0d required 1 3", acked, cnt);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL wait_fields got bad=1 required be=0011 wdata=12345678 and no ack0");
        end
    endtask

    task automatic test_stall();
        bit bad;
        q.push_back('{inst: 0, m: 1'b0, rd: 1'b1, data: 32'h5A5A_1234});
        @(posedge clk); #1;
        bi0.iReady = 0;
        bi0.iReadData = 32'h5A5A_1234;
        bi0.iReq0 = 1; bi0.iWe0 = 0; bi0.iAddr0 = 32'h3000_0100; bi0.iBE0 = 4'b1100;
        @(posedge clk);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bi0.oReadEnable !== 1'b1 || bi0.oAddress !== 32'h3000_0100 ||
                bi0.oByteEnable !== 4'b1100 || bi0.oAck0 !== 1'b0) bad = 1;
            bi0.iAddr0 = bi0.iAddr0 + 32'h4;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold got bad=1 required re=1 addr=30000100 be=1100 ack0=0 for 6 cycles");
        end
        bi0.iReady = 1;
        @(negedge clk);
        checks++;
        if (bi0.oAck0 !== 1'b1 || bi0.oReadEnable !== 1'b0) begin
            errors++;
            $display("FAIL stall_ack got ack0=%b re=%b required 1 0", bi0.oAck0, bi0.oReadEnable);
        end
        bi0.iReq0 = 0;
        @(negedge clk);
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_g [4];
        int n;
`ifdef ARB_ROUND_ROBIN_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
        apply_reset();
        for (int i = 0; i < 4; i++)
            q.push_back('{inst: 0, m: exp_g[i][1], rd: 1'b0, data: 32'h0});
        bi0.iReq0 = 1; bi0.iWe0 = 1; bi0.iAddr0 = 32'h0000_1000; bi0.iWData0 = 32'hAAAA_0000; bi0.iBE0 = 4'hF;
        bi0.iReq1 = 1; bi0.iWe1 = 1; bi0.iAddr1 = 32'h0000_2000; bi0.iWData1 = 32'hBBBB_0000; bi0.iBE1 = 4'hF;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (bi0.oAck0 || bi0.oAck1) begin
                checks++;
                if (bi0.oGrant !== exp_g[n]) begin
                    errors++;
                    $display("FAIL arb_grant_%0d got=%b required=%b", n, bi0.oGrant, exp_g[n]);
                end
                n++;
                if (n == 4) begin
                    bi0.iReq0 = 0;
                    bi0.iReq1 = 0;
                end
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL arb_count got acks=%0d required 4", n);
        end
        bi0.iReq0 = 0;
        bi0.iReq1 = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_single_read();
        test_wait_states();
        test_stall();
        test_arbitration();
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got pending=%0d required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
